oled_source_arbiter: RTL and testbench

- Shares the single OLED display pipeline (pixel_index in, 16-bit RGB565 pixel data out) among N_SRC independent pixel generators, e.g. per-task renderers.
- Ownership changes only at frame boundaries, so a frame never tears.
- Round-robin fairness with a minimum hold of MIN_FRAMES frames.
- Sits between the per-source pixel generators and the display driver's pixel_data input; runs in the 6.25 MHz display clock domain.

---
 rtl/oled_source_arbiter.sv | 137 +++++++++++++
 tb/tb_oled_source_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/oled_source_arbiter.sv
// rtl/oled_source_arbiter.sv - frame-boundary round-robin arbiter sharing one OLED pixel pipeline
module oled_source_arbiter #(
  parameter int          N_SRC       = 4,
  parameter int          MIN_FRAMES  = 2,
  parameter logic [15:0] IDLE_COLOUR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_begin,
  input  logic [N_SRC-1:0]     req,
  input  logic [16*N_SRC-1:0]  src_data,
  output logic [15:0]          oled_data,
  output logic [N_SRC-1:0]     grant,
  output logic                 grant_valid,
  output logic [N_SRC-1:0]     frame_ack,
  output logic [7:0]           frames_held
);

  localparam int PW = (N_SRC > 2) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [7:0]       held_q, held_d;
  logic [N_SRC-1:0] ack_q, ack_d;
  logic             first_q;

  logic             any_found, ex_found;
  logic [PW-1:0]    any_win, ex_win, idx;
  logic             take;
  logic [PW-1:0]    win;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (v == PW'(N_SRC - 1)) return '0;
    else return v + PW'(1);
  endfunction

  // Two scans from ptr: one over all requesters, one skipping the current owner.
  always_comb begin
    any_found = 1'b0;
    any_win   = '0;
    ex_found  = 1'b0;
    ex_win    = '0;
    idx       = ptr_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[idx]) begin
        if (!any_found) begin
          any_found = 1'b1;
          any_win   = idx;
        end
        if (!ex_found && !(state_q == OWN && idx == owner_q)) begin
          ex_found = 1'b1;
          ex_win   = idx;
        end
      end
      idx = wrap_inc(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    held_d  = held_q;
    ack_d   = '0;
    take    = 1'b0;
    win     = '0;
    // first_q masks a frame_begin coinciding with reset release.
    if (frame_begin && !first_q) begin
      case (state_q)
        IDLE: begin
          if (any_found) begin
            take = 1'b1;
            win  = any_win;
          end
        end
        OWN: begin
          if (!req[owner_q]) begin
            if (any_found) begin
              take = 1'b1;
              win  = any_win;
            end else begin
              state_d = IDLE;
              held_d  = 8'd0;
            end
          end else if (ex_found && held_q >= 8'(MIN_FRAMES)) begin
            take = 1'b1;
            win  = ex_win;
          end else if (held_q != 8'hFF) begin
            held_d = held_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (take) begin
        state_d = OWN;
        owner_d = win;
        ptr_d   = wrap_inc(win);
        held_d  = 8'd1;
      end
      if (state_d == OWN) ack_d = N_SRC'(1) << owner_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      held_q  <= 8'd0;
      ack_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      held_q  <= held_d;
      ack_q   <= ack_d;
      first_q <= 1'b0;
    end
  end

  assign grant_valid = (state_q == OWN);
  assign grant       = grant_valid ? (N_SRC'(1) << owner_q) : '0;
  assign frame_ack   = ack_q;
  assign frames_held = held_q;

  always_comb begin
    oled_data = IDLE_COLOUR;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant[k]) oled_data = src_data[16*k +: 16];
    end
  end

endmodule

// File: tb/tb_oled_source_arbiter.sv
// tb/tb_oled_source_arbiter.sv - scoreboard bench for oled_source_arbiter
module tb_oled_source_arbiter;

  localparam int N    = 4;
  localparam int MINF = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            frame_begin = 1'b0;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] src_data = '0;
  logic [16*N-1:0] sd_next = '0;
  logic [15:0]     oled_data;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [N-1:0]    frame_ack;
  logic [7:0]      frames_held;

  oled_source_arbiter #(.N_SRC(N), .MIN_FRAMES(MINF), .IDLE_COLOUR(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .frame_begin(frame_begin), .req(req),
    .src_data(src_data), .oled_data(oled_data), .grant(grant),
    .grant_valid(grant_valid), .frame_ack(frame_ack), .frames_held(frames_held)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] g;
    logic         v;
    logic [N-1:0] a;
    logic [7:0]   h;
    int           o;
  } exp_t;

  exp_t q[$];

  // Reference model: owner index (-1 = idle), pointer, hold count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_first = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int excl);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model(input bit rst, input bit fb, input logic [N-1:0] r);
    exp_t e;
    int   w;
    e.a = '0;
    if (!rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_first = 1'b1;
    end else begin
      if (fb && !m_first) begin
        w = -1;
        if (m_owner < 0) w = rr(r, -1);
        else if (!r[m_owner]) begin
          w = rr(r, -1);
          if (w < 0) begin m_owner = -1; m_held = 0; end
        end else begin
          w = rr(r, m_owner);
          if (m_held < MINF) w = -1;
          if (w < 0) m_held = (m_held >= 255) ? 255 : m_held + 1;
        end
        if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_held = 1; end
        if (m_owner >= 0) e.a = N'(1) << m_owner;
      end
      m_first = 1'b0;
    end
    e.o = m_owner;
    e.v = (m_owner >= 0);
    e.g = e.v ? (N'(1) << m_owner) : '0;
    e.h = 8'(m_held);
    q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit fb, input logic [N-1:0] r);
    @(negedge clk);
    reset_n = rst; frame_begin = fb; req = r; src_data = sd_next;
    model(rst, fb, r);
  endtask

  task automatic frame(input logic [N-1:0] r, input int len);
    cyc(1'b1, 1'b1, r);
    repeat (len - 1) cyc(1'b1, 1'b0, r);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t        e;
    logic [15:0] eo;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        eo = (e.o >= 0) ? src_data[16*e.o +: 16] : 16'h0000;
        chk("grant", 64'(grant), 64'(e.g));
        chk("grant_valid", 64'(grant_valid), 64'(e.v));
        chk("frame_ack", 64'(frame_ack), 64'(e.a));
        chk("frames_held", 64'(frames_held), 64'(e.h));
        chk("oled_data", 64'(oled_data), 64'(eo));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] gseq [6];
    logic [7:0]   hseq [6];
    gseq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    hseq = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    sd_next = {16'h001F, 16'hF800, 16'h07E0, 16'hAAAA};

    do_reset();
    @(posedge clk); #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_held", 64'(frames_held), 64'd0);

    // Idle frames: nothing granted, no acks.
    repeat (3) begin
      cyc(1'b1, 1'b1, 4'b0000);
      @(posedge clk); #2;
      chk("t1_ack", 64'(frame_ack), 64'd0);
      chk("t1_oled", 64'(oled_data), 64'h0000);
      cyc(1'b1, 1'b0, 4'b0000);
      cyc(1'b1, 1'b0, 4'b0000);
    end

    cyc(1'b1, 1'b1, 4'b0100);
    @(posedge clk); #2;
    chk("t2_grant", 64'(grant), 64'b0100);
    chk("t2_ack", 64'(frame_ack), 64'b0100);
    chk("t2_oled", 64'(oled_data), 64'hF800);
    chk("t2_held", 64'(frames_held), 64'd1);
    cyc(1'b1, 1'b0, 4'b0100);
    @(posedge clk); #2;
    chk("t2_ack_drop", 64'(frame_ack), 64'd0);
    cyc(1'b1, 1'b0, 4'b0100);

    do_reset();
    for (int f = 0; f < 6; f++) begin
      cyc(1'b1, 1'b1, 4'b0011);
      @(posedge clk); #2;
      chk("t3_grant", 64'(grant), 64'(gseq[f]));
      chk("t3_held", 64'(frames_held), 64'(hseq[f]));
      cyc(1'b1, 1'b0, 4'b0011);
      cyc(1'b1, 1'b0, 4'b0011);
    end

    // Owner 0 drops mid-frame; switch to 3 only on the next boundary.
    cyc(1'b1, 1'b0, 4'b1000);
    @(posedge clk); #2;
    chk("t4_hold", 64'(grant), 64'b0001);
    cyc(1'b1, 1'b0, 4'b1000);
    cyc(1'b1, 1'b1, 4'b1000);
    @(posedge clk); #2;
    chk("t4_grant", 64'(grant), 64'b1000);
    chk("t4_oled", 64'(oled_data), 64'h001F);
    cyc(1'b1, 1'b0, 4'b1000);

    do_reset();
    frame(4'b0010, 3);
    cyc(1'b1, 1'b1, 4'b0000);
    @(posedge clk); #2;
    chk("t5_grant", 64'(grant), 64'd0);
    chk("t5_valid", 64'(grant_valid), 64'd0);
    chk("t5_oled", 64'(oled_data), 64'h0000);
    chk("t5_held", 64'(frames_held), 64'd0);
    cyc(1'b1, 1'b0, 4'b0000);

    frame(4'b0010, 2);
    cyc(1'b1, 1'b0, 4'b0010);
    cyc(1'b0, 1'b0, 4'b1001);
    @(posedge clk); #2;
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_held", 64'(frames_held), 64'd0);
    cyc(1'b1, 1'b0, 4'b1001);
    cyc(1'b1, 1'b1, 4'b1001);
    @(posedge clk); #2;
    chk("t6_winner", 64'(grant), 64'b0001);
    cyc(1'b1, 1'b0, 4'b1001);

    // Hold count saturation with a sole requester.
    do_reset();
    repeat (260) frame(4'b0100, 2);
    @(posedge clk); #2;
    chk("sat_held", 64'(frames_held), 64'd255);

    // Randomized frames with mid-frame req changes and occasional resets.
    for (int f = 0; f < 150; f++) begin
      logic [N-1:0] r;
      int           len;
      r = N'($urandom_range(0, 15));
      len = $urandom_range(2, 5);
      sd_next = {$urandom(), $urandom()};
      cyc(1'b1, 1'b1, r);
      for (int c = 1; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
        if ($urandom_range(0, 40) == 0) cyc(1'b0, 1'b0, r);
        else cyc(1'b1, 1'b0, r);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
